// File: rtl/dht11_leitor.sv
// Single-wire DHT11/DHT22-style reader: issues the host start pulse, decodes the
// 40-bit response frame, verifies the checksum and publishes temperature/humidity.
module dht11_leitor #(
    parameter int unsigned CLKS_PER_US   = 50,
    parameter int unsigned START_LOW_US  = 18000,
    parameter int unsigned TIMEOUT_US    = 200,
    parameter int unsigned BIT_THRESH_US = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar,
    input  logic        dht_in,
    output logic        dht_drive_low,
    output logic [15:0] temp,
    output logic [15:0] umidade,
    output logic        pronto,
    output logic        ocupado,
    output logic        erro_checksum,
    output logic        erro_timeout
);

    localparam int unsigned PRE_W  = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam int unsigned MAX_A  = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
    localparam int unsigned US_MAX = (MAX_A > BIT_THRESH_US) ? MAX_A : BIT_THRESH_US;
    localparam int unsigned US_W   = $clog2(US_MAX + 1);

    localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(CLKS_PER_US - 1);
    localparam logic [US_W-1:0]  START_LAST   = US_W'(START_LOW_US - 1);
    localparam logic [US_W-1:0]  TIMEOUT_LAST = US_W'(TIMEOUT_US - 1);
    localparam logic [US_W-1:0]  THRESH       = US_W'(BIT_THRESH_US);

    typedef enum logic [2:0] {
        OCIOSO,
        PARTIDA,
        LIBERA,
        RESP_BAIXO,
        RESP_ALTO,
        BIT_BAIXO,
        BIT_ALTO,
        CONFERE
    } estado_t;

    estado_t          state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [US_W-1:0]  us_q, us_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [38:0]      shift_q, shift_d;
    logic [15:0]      temp_q, temp_d;
    logic [15:0]      umid_q, umid_d;
    logic             pronto_q, pronto_d;
    logic             echk_q, echk_d;
    logic             eto_q, eto_d;

    logic        rise, fall, tick, timeout, bit_val, aguarda;
    logic [39:0] frame;
    logic [7:0]  soma;

    always_comb begin
        sync1_d = dht_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    assign rise    = ~prev_q & sync2_q;
    assign fall    = prev_q & ~sync2_q;
    assign tick    = (presc_q == PRE_LAST);
    assign timeout = tick && (us_q == TIMEOUT_LAST);
    assign bit_val = (us_q >= THRESH);
    assign frame   = {shift_q, bit_val};
    assign soma    = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    assign aguarda = state_q inside {LIBERA, RESP_BAIXO, RESP_ALTO, BIT_BAIXO, BIT_ALTO};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        temp_d   = temp_q;
        umid_d   = umid_q;
        pronto_d = 1'b0;
        echk_d   = echk_q;
        eto_d    = eto_q;
        case (state_q)
            OCIOSO: begin
                if (iniciar) begin
                    state_d = PARTIDA;
                    echk_d  = 1'b0;
                    eto_d   = 1'b0;
                end
            end
            PARTIDA: begin
                if (tick && (us_q == START_LAST)) begin
                    state_d = LIBERA;
                end
            end
            LIBERA:     if (fall) state_d = RESP_BAIXO;
            RESP_BAIXO: if (rise) state_d = RESP_ALTO;
            RESP_ALTO: begin
                if (fall) begin
                    state_d = BIT_BAIXO;
                    cnt_d   = '0;
                end
            end
            BIT_BAIXO:  if (rise) state_d = BIT_ALTO;
            BIT_ALTO: begin
                if (fall) begin
                    shift_d = frame[38:0];
                    cnt_d   = cnt_q + 6'd1;
                    if (cnt_q == 6'd39) begin
                        // Checksum is resolved on the final edge so data and pronto appear together in CONFERE.
                        state_d = CONFERE;
                        if (soma == frame[7:0]) begin
                            umid_d   = frame[39:24];
                            temp_d   = frame[23:8];
                            pronto_d = 1'b1;
                        end else begin
                            echk_d = 1'b1;
                        end
                    end else begin
                        state_d = BIT_BAIXO;
                    end
                end
            end
            CONFERE:    state_d = OCIOSO;
            default:    state_d = OCIOSO;
        endcase
        if (aguarda && timeout && (state_d == state_q)) begin
            state_d = OCIOSO;
            eto_d   = 1'b1;
        end
    end

    // Edges seen while the host holds the line low are its own, so they do not stretch the start pulse.
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        us_d    = tick ? us_q + 1'b1 : us_q;
        if ((state_d != state_q) || ((rise || fall) && (state_q != PARTIDA))) begin
            presc_d = '0;
            us_d    = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= OCIOSO;
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            presc_q  <= '0;
            us_q     <= '0;
            cnt_q    <= '0;
            shift_q  <= '0;
            temp_q   <= '0;
            umid_q   <= '0;
            pronto_q <= 1'b0;
            echk_q   <= 1'b0;
            eto_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            presc_q  <= presc_d;
            us_q     <= us_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            temp_q   <= temp_d;
            umid_q   <= umid_d;
            pronto_q <= pronto_d;
            echk_q   <= echk_d;
            eto_q    <= eto_d;
        end
    end

    assign dht_drive_low = (state_q == PARTIDA);
    assign ocupado       = (state_q != OCIOSO);
    assign temp          = temp_q;
    assign umidade       = umid_q;
    assign pronto        = pronto_q;
    assign erro_checksum = echk_q;
    assign erro_timeout  = eto_q;

endmodule

// File: tb/tb_dht11_leitor.sv
// Bench for dht11_leitor: a sensor model drives framed pulses while an event-scheduled
// model of the outputs is compared against the DUT on every falling clock edge.
module tb_dht11_leitor;

    localparam int unsigned CPU   = 1;
    localparam int unsigned START = 20;
    localparam int unsigned TMO   = 200;
    localparam int unsigned THR   = 40;

    logic        clock, reset, iniciar, sensor_line;
    logic        dht_in, dht_drive_low, pronto, ocupado, erro_checksum, erro_timeout;
    logic [15:0] temp, umidade;

    // Open-drain line: the host buffer wins, otherwise the sensor (pull-up when released).
    assign dht_in = dht_drive_low ? 1'b0 : sensor_line;

    dht11_leitor #(
        .CLKS_PER_US  (CPU),
        .START_LOW_US (START),
        .TIMEOUT_US   (TMO),
        .BIT_THRESH_US(THR)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .dht_in       (dht_in),
        .dht_drive_low(dht_drive_low),
        .temp         (temp),
        .umidade      (umidade),
        .pronto       (pronto),
        .ocupado      (ocupado),
        .erro_checksum(erro_checksum),
        .erro_timeout (erro_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef enum int {K_DRV, K_OCUP, K_PRONTO, K_TEMP, K_UMID, K_ECHK, K_ETO, K_RST} kind_t;
    typedef struct {
        int          at;
        kind_t       kind;
        logic [15:0] val;
    } ev_t;

    ev_t         evq[$];
    logic        e_drv = 0, e_ocup = 0, e_pronto = 0, e_echk = 0, e_eto = 0;
    logic [15:0] e_temp = '0, e_umid = '0;
    int          n_cmp = 0, n_bad = 0, pr_cnt = 0, drv_cnt = 0;
    bit          chk_en = 0;

    function automatic void push(input int at, input kind_t k, input logic [15:0] v);
        ev_t e;
        e.at = at; e.kind = k; e.val = v;
        evq.push_back(e);
    endfunction

    function automatic void apply(input ev_t e);
        case (e.kind)
            K_DRV:    e_drv    = e.val[0];
            K_OCUP:   e_ocup   = e.val[0];
            K_PRONTO: e_pronto = e.val[0];
            K_TEMP:   e_temp   = e.val;
            K_UMID:   e_umid   = e.val;
            K_ECHK:   e_echk   = e.val[0];
            K_ETO:    e_eto    = e.val[0];
            K_RST: begin
                e_drv = 0; e_ocup = 0; e_pronto = 0; e_echk = 0; e_eto = 0;
                e_temp = '0; e_umid = '0;
            end
            default: ;
        endcase
    endfunction

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin : compare_p
        int k;
        if (chk_en) begin
            k = 0;
            while (k < evq.size()) begin
                if (evq[k].at <= cyc) begin
                    apply(evq[k]);
                    evq.delete(k);
                end else begin
                    k++;
                end
            end
            cmp("dht_drive_low", {15'b0, dht_drive_low}, {15'b0, e_drv});
            cmp("ocupado",       {15'b0, ocupado},       {15'b0, e_ocup});
            cmp("pronto",        {15'b0, pronto},        {15'b0, e_pronto});
            cmp("erro_checksum", {15'b0, erro_checksum}, {15'b0, e_echk});
            cmp("erro_timeout",  {15'b0, erro_timeout},  {15'b0, e_eto});
            cmp("temp",          temp,                   e_temp);
            cmp("umidade",       umidade,                e_umid);
            if (pronto === 1'b1) pr_cnt++;
            if (dht_drive_low === 1'b1) drv_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One measurement: bytes b0..b4 on the wire, zero/one high widths w0/w1 (us).
    // silent: sensor never answers; stop_after: bits sent before the sensor freezes low;
    // ini_bit/rst_bit: bit during whose high phase iniciar/reset is pulsed (-1 = never).
    task automatic run_frame(input logic [7:0] b0, b1, b2, b3, b4, input int w0, w1,
                             input bit silent, input int stop_after, input int ini_bit,
                             input int rst_bit);
        logic [39:0] frame;
        logic [39:0] got;
        logic        bv;
        int          i0, x, w, sum;
        frame = {b0, b1, b2, b3, b4};
        got   = '0;
        x     = 0;
        i0    = cyc;
        iniciar = 1'b1;
        push(i0 + 1, K_OCUP, 16'd1);
        push(i0 + 1, K_DRV, 16'd1);
        push(i0 + 1, K_ECHK, 16'd0);
        push(i0 + 1, K_ETO, 16'd0);
        push(i0 + 1 + START, K_DRV, 16'd0);
        step(1);
        iniciar = 1'b0;
        step(START);
        if (silent) begin
            // Last line activity is the release itself; abort 3 sync/detect cycles + timeout later.
            push(cyc + 3 + TMO, K_ETO, 16'd1);
            push(cyc + 3 + TMO, K_OCUP, 16'd0);
            step(TMO + 10);
            return;
        end
        step(20);  sensor_line = 1'b0;
        step(80);  sensor_line = 1'b1;
        step(80);  sensor_line = 1'b0;
        for (int b = 0; b < 40; b++) begin
            step(50);
            sensor_line = 1'b1;
            w = frame[39-b] ? w1 : w0;
            if (b == rst_bit) begin
                step(w / 2);
                reset = 1'b1;
                push(cyc + 1, K_RST, 16'd0);
                step(1);
                reset = 1'b0;
                cmp("reset_temp",    temp,               16'h0000);
                cmp("reset_umidade", umidade,            16'h0000);
                cmp("reset_ocupado", {15'b0, ocupado},   16'h0000);
                cmp("reset_drive",   {15'b0, dht_drive_low}, 16'h0000);
                step(20);
                return;
            end
            if (b == ini_bit) begin
                step(w / 2);
                iniciar = 1'b1;
                step(1);
                iniciar = 1'b0;
                step(w - w / 2 - 1);
            end else begin
                step(w);
            end
            sensor_line = 1'b0;
            x  = cyc;
            bv = (w > THR);
            got = {got[38:0], bv};
            if (b + 1 == stop_after) begin
                push(x + 3 + TMO, K_ETO, 16'd1);
                push(x + 3 + TMO, K_OCUP, 16'd0);
                step(TMO + 10);
                sensor_line = 1'b1;
                step(5);
                return;
            end
        end
        sum = (int'(got[39:32]) + int'(got[31:24]) + int'(got[23:16]) + int'(got[15:8])) % 256;
        if (sum == int'(got[7:0])) begin
            push(x + 3, K_UMID, got[39:24]);
            push(x + 3, K_TEMP, got[23:8]);
            push(x + 3, K_PRONTO, 16'd1);
            push(x + 4, K_PRONTO, 16'd0);
        end else begin
            push(x + 3, K_ECHK, 16'd1);
        end
        push(x + 4, K_OCUP, 16'd0);
        step(50);
        sensor_line = 1'b1;
        step(10);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int pr0;
        reset = 1'b1; iniciar = 1'b0; sensor_line = 1'b1;
        step(1);
        chk_en = 1;
        step(2);
        cmp("rst_temp",    temp,    16'h0000);
        cmp("rst_umidade", umidade, 16'h0000);
        cmp("rst_ocupado", {15'b0, ocupado}, 16'h0000);
        reset = 1'b0;
        step(5);

        // 54.2 % / 27.2 C, good checksum
        drv_cnt = 0; pr0 = pr_cnt;
        run_frame(8'h36, 8'h02, 8'h1B, 8'h02, 8'd85, 27, 70, 0, -1, -1, -1);
        cmp("f1_umidade", umidade, 16'h3602);
        cmp("f1_temp",    temp,    16'h1B02);
        cmp("f1_pronto_pulses", 16'(pr_cnt - pr0), 16'd1);
        cmp("f1_drive_low_us",  16'(drv_cnt), 16'd20);
        cmp("f1_erro_checksum", {15'b0, erro_checksum}, 16'h0000);

        // same frame, bad checksum
        pr0 = pr_cnt;
        run_frame(8'h36, 8'h02, 8'h1B, 8'h02, 8'd86, 27, 70, 0, -1, -1, -1);
        cmp("f2_erro_checksum", {15'b0, erro_checksum}, 16'h0001);
        cmp("f2_pronto_pulses", 16'(pr_cnt - pr0), 16'd0);
        cmp("f2_temp",    temp,    16'h1B02);
        cmp("f2_umidade", umidade, 16'h3602);

        // silent sensor
        run_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 27, 70, 1, -1, -1, -1);
        cmp("f3_erro_checksum", {15'b0, erro_checksum}, 16'h0000);
        cmp("f3_erro_timeout",  {15'b0, erro_timeout},  16'h0001);
        cmp("f3_ocupado",       {15'b0, ocupado},       16'h0000);

        // sensor freezes after bit 17
        run_frame(8'h36, 8'h02, 8'h1B, 8'h02, 8'd85, 27, 70, 0, 17, -1, -1);
        cmp("f4_erro_timeout", {15'b0, erro_timeout}, 16'h0001);
        cmp("f4_temp", temp, 16'h1B02);

        // 22.5 % / 18.5 C with 40 us zeros and 41 us ones
        run_frame(8'h16, 8'h05, 8'h12, 8'h05, 8'h32, 40, 41, 0, -1, -1, -1);
        cmp("f5_temp",    temp,    16'h1205);
        cmp("f5_umidade", umidade, 16'h1605);
        cmp("f5_erro_timeout", {15'b0, erro_timeout}, 16'h0000);

        // iniciar pulsed while a bit is high
        pr0 = pr_cnt;
        run_frame(8'h36, 8'h02, 8'h1B, 8'h02, 8'd85, 27, 70, 0, -1, 5, -1);
        cmp("f6_temp", temp, 16'h1B02);
        cmp("f6_pronto_pulses", 16'(pr_cnt - pr0), 16'd1);
        cmp("f6_ocupado", {15'b0, ocupado}, 16'h0000);

        // reset mid-frame
        run_frame(8'h3C, 8'h00, 8'h20, 8'h05, 8'h61, 27, 70, 0, -1, -1, 20);

        // 60.0 % / 32.5 C after reset
        run_frame(8'h3C, 8'h00, 8'h20, 8'h05, 8'h61, 27, 70, 0, -1, -1, -1);
        cmp("f8_temp",    temp,    16'h2005);
        cmp("f8_umidade", umidade, 16'h3C00);

        step(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dht11_leitor.md
Name: dht11_leitor

Overview:
- Single-wire DHT11/DHT22-style sensor reader; the producer of the `temp` and `umidade` words consumed by `tusca_fd`.
- Issues the host start pulse, decodes the sensor's 40-bit response frame and verifies the checksum.
- Publishes `{int,dec}` 16-bit temperature and humidity registers plus status flags.
- Sits between the board pin (external tri-state buffer) and `tusca_fd`.

Parameters:
- `CLKS_PER_US`, default 50: clock cycles per microsecond; all timing is derived from it.
- `START_LOW_US`, default 18000: duration the host drives the line low for the start pulse.
- `TIMEOUT_US`, default 200: maximum duration of any single line level before abort.
- `BIT_THRESH_US`, default 40: a bit-high pulse longer than this decodes as 1.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `iniciar` in 1: one-cycle request to start a measurement.
- `dht_in` in 1: sampled data line (asynchronous to `clock`).
- `dht_drive_low` out 1: 1 = external buffer pulls the line low; 0 = line released.
- `temp` out 16: `{integer byte, decimal byte}` temperature of the last valid frame.
- `umidade` out 16: `{integer byte, decimal byte}` humidity of the last valid frame.
- `pronto` out 1: one-cycle pulse when a valid frame has been latched.
- `ocupado` out 1: high in every state except `OCIOSO`.
- `erro_checksum` out 1: sticky; set on checksum mismatch; cleared by the next accepted `iniciar` or by `reset`.
- `erro_timeout` out 1: sticky; set on timeout; cleared by the next accepted `iniciar` or by `reset`.

Behaviour:
- Reset (synchronous; overrides everything, including mid-transfer):
  - State = `OCIOSO`; line released.
  - `dht_drive_low`=0, `temp`=0, `umidade`=0, `pronto`=0, `ocupado`=0, `erro_checksum`=0, `erro_timeout`=0.
  - Bit counter, timer and shift register cleared.
- Input sync: `dht_in` passes through a 2-FF synchronizer. All edge detection uses the synced value and its previous sample.
- Timer: a single up-counter in microsecond ticks, built from a prescaler that rolls over at `CLKS_PER_US`-1. It restarts on every state entry and on every synced edge.
- FSM:
  - `OCIOSO`: `iniciar`=1 -> `PARTIDA`. Entering `PARTIDA` clears both error flags. `iniciar` is ignored in all other states.
  - `PARTIDA`: `dht_drive_low`=1 for `START_LOW_US`, then -> `LIBERA`.
  - `LIBERA`: line released; wait for a synced falling edge -> `RESP_BAIXO`.
  - `RESP_BAIXO`: wait for rising edge -> `RESP_ALTO`.
  - `RESP_ALTO`: wait for falling edge -> `BIT_BAIXO`; bit counter = 0.
  - `BIT_BAIXO`: wait for rising edge -> `BIT_ALTO`.
  - `BIT_ALTO`: on falling edge:
    - Shift in a bit, MSB first: 1 if high time > `BIT_THRESH_US` us, else 0. Exactly `BIT_THRESH_US` decodes as 0.
    - Bit counter += 1.
    - If bit counter reaches 40 -> `CONFERE`; else -> `BIT_BAIXO`.
  - `CONFERE` (1 cycle): frame = `{umid_int, umid_dec, temp_int, temp_dec, chk}`.
    - If `(umid_int+umid_dec+temp_int+temp_dec) mod 256 == chk`: latch `umidade={umid_int,umid_dec}` and `temp={temp_int,temp_dec}`; `pronto`=1 for this one cycle.
    - Else set `erro_checksum`; `temp` and `umidade` hold their previous values.
    - -> `OCIOSO`.
  - Timeout: in `LIBERA` through `BIT_ALTO`, if the timer reaches `TIMEOUT_US` -> set `erro_timeout`, release the line, -> `OCIOSO`. Outputs hold their previous values.
- Latency: `pronto` is asserted the cycle after the 40th falling edge is detected, i.e. 3 cycles after the raw pin edge.
- `temp` and `umidade` change only in the `CONFERE` cycle with a good checksum.
- The final sensor release after bit 40 is not waited on.

Test Plan:
- Use `CLKS_PER_US`=1, `START_LOW_US`=20; sensor model: 80/80 us response, 50 us low per bit, 27 us high for 0, 70 us high for 1.
- Frame 54.2 %, 27.2 C, chk 85 -> `umidade`=16'h3602, `temp`=16'h1B02, one `pronto` pulse, error flags 0; `dht_drive_low` high for exactly 20 us after `iniciar`.
- Same frame with chk 86 -> `erro_checksum`=1, no `pronto`; `temp`/`umidade` keep 16'h1B02/16'h3602; next `iniciar` clears the flag.
- Sensor silent after release -> `erro_timeout`=1 at 200 us in `LIBERA`, `ocupado` falls, line released; also stop the sensor after bit 17 -> timeout, outputs unchanged.
- Bit-high widths of 40 us and 41 us -> decoded as 0 and 1 respectively (frame 18.5 C / 22.5 % verifies all bytes).
- `iniciar` pulsed during `BIT_ALTO` -> ignored, frame completes normally; `reset` asserted mid-frame -> next cycle all outputs 0, state `OCIOSO`; a fresh `iniciar` reads 32.5 C correctly.
